interrupt_init_sequencer: RTL and testbench

INTERRUPT_INIT_SEQUENCER -- requirements
Module: interrupt_init_sequencer

---
 rtl/interrupt_init_sequencer.sv | 145 ++++++++++++++
 tb/tb_interrupt_init_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/interrupt_init_sequencer.sv
// rtl/interrupt_init_sequencer.sv - 8259-style ICW/OCW write sequencer
// A write commits on the cycle after the strobe drops; all decode uses the latched address/data.
module interrupt_init_sequencer #(
   parameter logic [7:0] IMR_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       CS_bar,
   input  logic       WR_bar,
   input  logic       A0,
   input  logic [7:0] data_in,
   output logic [2:0] state,
   output logic       init_done,
   output logic       ltim,
   output logic       single,
   output logic       ic4,
   output logic [4:0] vector_base,
   output logic [7:0] cascade_cfg,
   output logic       upm,
   output logic       aeoi,
   output logic       ms,
   output logic       buf_mode,
   output logic       sfnm,
   output logic [7:0] imr,
   output logic [7:0] ocw2_cmd,
   output logic       read_isr,
   output logic       smm,
   output logic       icw1_pulse,
   output logic       ocw1_pulse,
   output logic       ocw2_pulse,
   output logic       poll_pulse
);

   typedef enum logic [2:0] {
      WAIT_ICW1 = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       active, wr_q, a0_q, commit;
   logic [7:0] data_q;
   logic       icw1_wr, icw_data_wr, ocw1_wr, ocw2_wr, ocw3_wr;

   assign active = ~CS_bar & ~WR_bar;
   assign commit = wr_q & ~active;
   assign state  = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= 1'b0;
         a0_q   <= 1'b0;
         data_q <= 8'h00;
      end else begin
         wr_q <= active;
         if (active) begin
            a0_q   <= A0;
            data_q <= data_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= WAIT_ICW1;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (commit) begin
         if (~a0_q & data_q[4]) begin
            state_d = WAIT_ICW2;
         end else if (a0_q) begin
            case (state_q)
               WAIT_ICW2: state_d = ~single ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
               WAIT_ICW3: state_d = ic4 ? WAIT_ICW4 : READY;
               WAIT_ICW4: state_d = READY;
               WAIT_ICW1,
               READY:     state_d = state_q;
               default:   state_d = WAIT_ICW1;
            endcase
         end
      end
   end

   always_comb begin
      init_done   = (state_q == READY);
      icw1_wr     = commit & ~a0_q & data_q[4];
      icw_data_wr = commit & a0_q;
      ocw1_wr     = commit & a0_q & (state_q == READY);
      ocw2_wr     = commit & ~a0_q & ~data_q[4] & ~data_q[3] & (state_q == READY);
      ocw3_wr     = commit & ~a0_q & ~data_q[4] &  data_q[3] & (state_q == READY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ltim        <= 1'b0;
         single      <= 1'b0;
         ic4         <= 1'b0;
         vector_base <= 5'd0;
         cascade_cfg <= 8'h00;
         {sfnm, buf_mode, ms, aeoi, upm} <= 5'b0;
         imr         <= IMR_INIT;
         ocw2_cmd    <= 8'h00;
         read_isr    <= 1'b0;
         smm         <= 1'b0;
         icw1_pulse  <= 1'b0;
         ocw1_pulse  <= 1'b0;
         ocw2_pulse  <= 1'b0;
         poll_pulse  <= 1'b0;
      end else begin
         icw1_pulse <= icw1_wr;
         ocw1_pulse <= ocw1_wr;
         ocw2_pulse <= ocw2_wr;
         poll_pulse <= ocw3_wr & data_q[2];
         // ICW1 restarts init but deliberately keeps vector_base/cascade_cfg
         if (icw1_wr) begin
            ltim     <= data_q[3];
            single   <= data_q[1];
            ic4      <= data_q[0];
            imr      <= IMR_INIT;
            read_isr <= 1'b0;
            smm      <= 1'b0;
            {sfnm, buf_mode, ms, aeoi, upm} <= 5'b0;
         end
         if (icw_data_wr) begin
            case (state_q)
               WAIT_ICW2: vector_base <= data_q[7:3];
               WAIT_ICW3: cascade_cfg <= data_q;
               WAIT_ICW4: {sfnm, buf_mode, ms, aeoi, upm} <= data_q[4:0];
               default:   ;
            endcase
         end
         if (ocw1_wr) imr      <= data_q;
         if (ocw2_wr) ocw2_cmd <= data_q;
         if (ocw3_wr) begin
            if (data_q[1]) read_isr <= data_q[0];
            if (data_q[6]) smm      <= data_q[5];
         end
      end
   end

endmodule

// File: tb/tb_interrupt_init_sequencer.sv
// tb/tb_interrupt_init_sequencer.sv - directed scoreboard bench for interrupt_init_sequencer
module tb_interrupt_init_sequencer;

   localparam logic [7:0] IMR_INIT = 8'h5A;

   logic       clk = 1'b0;
   logic       reset, CS_bar, WR_bar, A0;
   logic [7:0] data_in;
   logic [2:0] state;
   logic       init_done, ltim, single, ic4, upm, aeoi, ms, buf_mode, sfnm;
   logic [4:0] vector_base;
   logic [7:0] cascade_cfg, imr, ocw2_cmd;
   logic       read_isr, smm, icw1_pulse, ocw1_pulse, ocw2_pulse, poll_pulse;

   always #5 clk = ~clk;

   interrupt_init_sequencer #(.IMR_INIT(IMR_INIT)) dut (
      .clk(clk), .reset(reset), .CS_bar(CS_bar), .WR_bar(WR_bar), .A0(A0), .data_in(data_in),
      .state(state), .init_done(init_done), .ltim(ltim), .single(single), .ic4(ic4),
      .vector_base(vector_base), .cascade_cfg(cascade_cfg), .upm(upm), .aeoi(aeoi), .ms(ms),
      .buf_mode(buf_mode), .sfnm(sfnm), .imr(imr), .ocw2_cmd(ocw2_cmd), .read_isr(read_isr),
      .smm(smm), .icw1_pulse(icw1_pulse), .ocw1_pulse(ocw1_pulse), .ocw2_pulse(ocw2_pulse),
      .poll_pulse(poll_pulse)
   );

   typedef struct {
      string       tag;
      logic [46:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [2:0] m_state;
   logic       m_ltim, m_single, m_ic4, m_read_isr, m_smm;
   logic [4:0] m_vb, m_icw4;
   logic [7:0] m_casc, m_imr, m_ocw2;
   logic [3:0] m_pulse;

   function automatic logic [46:0] dut_vec();
      return {state, init_done, ltim, single, ic4, vector_base, cascade_cfg,
              upm, aeoi, ms, buf_mode, sfnm, imr, ocw2_cmd, read_isr, smm,
              icw1_pulse, ocw1_pulse, ocw2_pulse, poll_pulse};
   endfunction

   function automatic logic [46:0] model_vec();
      return {m_state, (m_state == 3'd4), m_ltim, m_single, m_ic4, m_vb, m_casc,
              m_icw4[0], m_icw4[1], m_icw4[2], m_icw4[3], m_icw4[4], m_imr, m_ocw2,
              m_read_isr, m_smm, m_pulse};
   endfunction

   task automatic check(input string tag, input logic [46:0] got, input logic [46:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 3'd0; m_ltim = 0; m_single = 0; m_ic4 = 0; m_read_isr = 0; m_smm = 0;
      m_vb = 5'd0; m_icw4 = 5'd0; m_casc = 8'h00; m_imr = IMR_INIT; m_ocw2 = 8'h00; m_pulse = 4'b0;
   endtask

   task automatic model_commit(input logic a0, input logic [7:0] d);
      m_pulse = 4'b0;
      if (!a0 && d[4]) begin
         m_ltim = d[3]; m_single = d[1]; m_ic4 = d[0];
         m_imr = IMR_INIT; m_read_isr = 0; m_smm = 0; m_icw4 = 5'd0;
         m_pulse = 4'b1000; m_state = 3'd1;
      end else if (a0) begin
         if (m_state == 3'd1) begin
            m_vb = d[7:3];
            m_state = !m_single ? 3'd2 : (m_ic4 ? 3'd3 : 3'd4);
         end else if (m_state == 3'd2) begin
            m_casc = d;
            m_state = m_ic4 ? 3'd3 : 3'd4;
         end else if (m_state == 3'd3) begin
            m_icw4 = d[4:0];
            m_state = 3'd4;
         end else if (m_state == 3'd4) begin
            m_imr = d;
            m_pulse = 4'b0100;
         end
      end else if (m_state == 3'd4) begin
         if (!d[3]) begin
            m_ocw2 = d;
            m_pulse = 4'b0010;
         end else begin
            if (d[1]) m_read_isr = d[0];
            if (d[6]) m_smm = d[5];
            m_pulse = {3'b000, d[2]};
         end
      end
   endtask

   // Expected commit-cycle and settle-cycle snapshots are queued before the DUT reaches them.
   task automatic do_write(input string tag, input logic a0, input logic [7:0] d);
      exp_t e;
      @(negedge clk); CS_bar = 0; WR_bar = 0; A0 = a0; data_in = d;
      @(negedge clk); CS_bar = 1; WR_bar = 1;
      model_commit(a0, d);
      e.tag = {tag, " commit"}; e.vec = model_vec(); exp_q.push_back(e);
      m_pulse = 4'b0;
      e.tag = {tag, " settle"}; e.vec = model_vec(); exp_q.push_back(e);
      repeat (2) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check(e.tag, dut_vec(), e.vec);
      end
   endtask

   task automatic idle_check(input string tag, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.tag = tag; e.vec = model_vec(); exp_q.push_back(e);
         @(negedge clk);
         e = exp_q.pop_front();
         check(e.tag, dut_vec(), e.vec);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      check(tag, {39'd0, got}, {39'd0, exp});
   endtask

   initial begin
      reset = 1; CS_bar = 1; WR_bar = 1; A0 = 0; data_in = 8'h00;
      repeat (2) @(negedge clk);
      reset = 0;
      model_reset();
      check("reset snapshot", dut_vec(), model_vec());
      check8("reset imr", imr, 8'h5A);
      check8("reset state", {5'd0, state}, 8'd0);

      do_write("A0=1 in WAIT_ICW1", 1'b1, 8'hA5);

      do_write("ICW1 13", 1'b0, 8'h13);
      check8("ICW1 13 state", {5'd0, state}, 8'd1);
      do_write("ICW2 20", 1'b1, 8'h20);
      check8("ICW2 20 state", {5'd0, state}, 8'd3);
      do_write("ICW4 03", 1'b1, 8'h03);
      check8("ICW4 03 state", {5'd0, state}, 8'd4);
      check8("vector_base 04", {3'd0, vector_base}, 8'h04);
      check8("upm/aeoi/init_done", {5'd0, upm, aeoi, init_done}, 8'h07);

      do_write("ICW1 11", 1'b0, 8'h11);
      do_write("ICW2 40", 1'b1, 8'h40);
      check8("ICW2 40 state", {5'd0, state}, 8'd2);
      do_write("ICW3 04", 1'b1, 8'h04);
      do_write("ICW4 01", 1'b1, 8'h01);
      check8("cascade_cfg", cascade_cfg, 8'h04);
      check8("single", {7'd0, single}, 8'd0);

      do_write("OCW1 A5", 1'b1, 8'hA5);
      check8("imr A5", imr, 8'hA5);
      do_write("OCW2 20", 1'b0, 8'h20);
      check8("ocw2_cmd 20", ocw2_cmd, 8'h20);
      do_write("OCW3 0B", 1'b0, 8'h0B);
      check8("read_isr", {7'd0, read_isr}, 8'd1);
      do_write("OCW3 0C poll", 1'b0, 8'h0C);
      do_write("OCW3 6A smm", 1'b0, 8'h6A);

      do_write("ICW1 11 again", 1'b0, 8'h11);
      do_write("OCW2 in WAIT_ICW2", 1'b0, 8'h20);
      do_write("ICW1 12 restart", 1'b0, 8'h12);
      check8("restart imr", imr, 8'h5A);
      check8("cascade retained", cascade_cfg, 8'h04);
      do_write("ICW2 F8 to READY", 1'b1, 8'hF8);
      check8("single no ic4 state", {5'd0, state}, 8'd4);

      // CS_bar high: strobe activity must never become a commit
      @(negedge clk); CS_bar = 1; WR_bar = 0; A0 = 0; data_in = 8'h13;
      idle_check("CS high write", 5);
      WR_bar = 1;
      idle_check("CS high release", 2);

      @(negedge clk); CS_bar = 0; WR_bar = 0; A0 = 0; data_in = 8'h13;
      @(negedge clk); reset = 1;
      @(negedge clk); reset = 0; CS_bar = 1; WR_bar = 1;
      model_reset();
      check("reset during write", dut_vec(), model_vec());
      idle_check("after reset release", 3);
      check8("post-reset state", {5'd0, state}, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
